// File: rtl/hex_display_pkg.sv
// hex_display_pkg: shared segment bit order, glyph table and blank code for the hex display.
//   SEG_W  : segments per digit (bit 0 = seg a ... bit 6 = seg g)
//   GLYPH  : active-low glyphs for nibbles 0..F
//   BLANK  : active-low code with every segment off
package hex_display_pkg;
   typedef enum logic [2:0] {SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G} seg_e;
   localparam int SEG_W = 7;
   localparam logic [SEG_W-1:0] BLANK = 7'h7F;
   localparam logic [SEG_W-1:0] GLYPH [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };
endpackage

// File: rtl/seg7_glyph.sv
// seg7_glyph: combinational nibble to active-low 7-segment glyph.
//   nibble : 4-bit hex digit
//   seg    : active-low segments, bit 0 = seg a ... bit 6 = seg g
module seg7_glyph
   import hex_display_pkg::*;
(
   input  logic [3:0]       nibble,
   output logic [SEG_W-1:0] seg
);
   assign seg = GLYPH[nibble];
endmodule

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: registered multi-digit hex display with leading-zero blanking, per-digit enable and blink.
//   clock       : rising-edge system clock
//   resetn      : asynchronous active-low reset
//   load        : capture strobe for value
//   value       : nibble k = digit k, digit 0 least significant
//   digit_en    : per-digit enable, 0 blanks that digit
//   blank_lz    : leading-zero blanking enable
//   blink_en    : blink mode enable
//   hex         : active-low segments, digit k at [7k+6:7k]
//   blink_phase : current blink phase, 1 = display blanked
module hex_display_ctrl
   import hex_display_pkg::*;
#(
   parameter int NUM_DIGITS   = 6,
   parameter int BLINK_CYCLES = 25000000
) (
   input  logic                          clock,
   input  logic                          resetn,
   input  logic                          load,
   input  logic [4*NUM_DIGITS-1:0]       value,
   input  logic [NUM_DIGITS-1:0]         digit_en,
   input  logic                          blank_lz,
   input  logic                          blink_en,
   output logic [SEG_W*NUM_DIGITS-1:0]   hex,
   output logic                          blink_phase
);
   localparam int CW = $clog2(BLINK_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_CYCLES - 1);
   logic [4*NUM_DIGITS-1:0]     value_q;
   logic [CW-1:0]               cnt;
   logic [NUM_DIGITS-1:0]       show;
   logic [SEG_W*NUM_DIGITS-1:0] hex_d;
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         value_q     <= '0;
         cnt         <= '0;
         blink_phase <= 1'b0;
         hex         <= '1;
      end else begin
         if (load) value_q <= value;
         cnt         <= !blink_en || cnt == CNT_MAX ? '0 : cnt + 1'b1;
         blink_phase <= blink_en && (blink_phase ^ (cnt == CNT_MAX));
         hex         <= hex_d;
      end
   // Scan from the top digit down: once a non-zero nibble is seen, every lower digit is significant.
   // Digit 0 is always significant so an all-zero value still shows one 0.
   always_comb begin : lz_mask
      logic seen;
      seen = 1'b0;
      show = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         seen    = seen || value_q[4*k +: 4] != 4'd0 || k == 0;
         show[k] = seen || !blank_lz;
      end
   end
   for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
      logic [SEG_W-1:0] seg;
      seg7_glyph u_glyph (.nibble(value_q[4*d +: 4]), .seg(seg));
      assign hex_d[SEG_W*d +: SEG_W] = digit_en[d] && show[d] && !blink_phase ? seg : BLANK;
   end
endmodule
